// File: rtl/cic_pkg.sv
// Shared CIC constants and width helpers.
// Both the interpolating and decimating halves import this package so they agree on widths.
package cic_pkg;

    localparam int CIC_N_STAGES = 3;
    localparam int CIC_DECIM    = 4;
    localparam int CIC_IN_W     = 8;
    localparam int CIC_ACC_W    = 14;

    // Bit growth of an N-stage CIC at rate change R (M = 1).
    function automatic int cic_growth(input int n, input int r);
        return n * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_d_if.sv
// Sample stream into, and decimated stream out of, the CIC comb section.
interface cic_d_if #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 14
);
    logic [IN_W-1:0]  data_in;
    logic             in_dv;
    logic [OUT_W-1:0] data_out;
    logic             out_dv;

    modport master (
        output data_in,
        output in_dv,
        input  data_out,
        input  out_dv
    );

    modport slave (
        input  data_in,
        input  in_dv,
        output data_out,
        output out_dv
    );
endinterface

// File: rtl/cic_d_comb_stage.sv
// One CIC comb (differentiator) stage with differential delay M = 1.
// The subtraction wraps modulo 2^W; the CIC relies on that wrap to cancel integrator overflow.
module cic_comb_stage #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_x,
    input  logic         i_x_v,
    output logic [W-1:0] o_y,
    output logic         o_y_v
);

    logic [W-1:0] r_d;
    logic [W-1:0] r_y;
    logic         r_y_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d   <= '0;
            r_y   <= '0;
            r_y_v <= 1'b0;
        end else begin
            r_y_v <= i_x_v;
            if (i_x_v) begin
                r_y <= i_x - r_d;
                r_d <= i_x;
            end
        end
    end

    assign o_y   = r_y;
    assign o_y_v = r_y_v;

endmodule

// File: rtl/cic_d.sv
// Decimating CIC comb section: keeps every DECIM-th valid integrator sample and
// differentiates it through N_STAGES pipelined comb stages.
module cic_d
    import cic_pkg::*;
#(
    parameter int IN_W     = CIC_ACC_W,
    parameter int OUT_W    = CIC_ACC_W,
    parameter int N_STAGES = CIC_N_STAGES,
    parameter int DECIM    = CIC_DECIM
) (
    input  logic    clk,
    input  logic    reset,
    cic_d_if.slave  bus
);

    localparam int CNT_W = (DECIM > 1) ? cic_growth(1, DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [IN_W-1:0]  r_sample;
    logic             r_dec_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sample <= '0;
            r_dec_v  <= 1'b0;
        end else begin
            r_dec_v <= 1'b0;
            if (bus.in_dv) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt    <= '0;
                    r_sample <= bus.data_in;
                    r_dec_v  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Index 0 is the kept sample; index k is the output of comb stage k.
    logic [IN_W-1:0] w_x [0:N_STAGES];
    logic            w_v [0:N_STAGES];

    assign w_x[0] = r_sample;
    assign w_v[0] = r_dec_v;

    genvar gi;
    generate
        for (gi = 0; gi < N_STAGES; gi++) begin : g_comb
            cic_comb_stage #(
                .W (IN_W)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .i_x   (w_x[gi]),
                .i_x_v (w_v[gi]),
                .o_y   (w_x[gi+1]),
                .o_y_v (w_v[gi+1])
            );
        end
    endgenerate

    // The last stage only updates on its own advance, so the output holds between strobes.
    assign bus.data_out = w_x[N_STAGES][IN_W-1 -: OUT_W];
    assign bus.out_dv   = w_v[N_STAGES];

endmodule

// File: tb/tb_cic_d.sv
// Directed self-checking bench for the cic_d decimating comb section.
module tb_cic_d;
    import cic_pkg::*;

    localparam int IN_W  = CIC_ACC_W;
    localparam int OUT_W = CIC_ACC_W;
    localparam int N     = CIC_N_STAGES;
    localparam int R     = CIC_DECIM;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cic_d_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    cic_d #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .N_STAGES (N),
        .DECIM    (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [OUT_W-1:0] out_q  [$];
    int               ocyc_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.out_dv) begin
            out_q.push_back(bus.data_out);
            ocyc_q.push_back(cyc);
            $display("[TB] cyc %0d out_dv data_out=0x%04h", cyc, bus.data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one input for one clock edge; returns at the following falling edge.
    task automatic drive(input logic v, input logic [IN_W-1:0] d);
        bus.in_dv   = v;
        bus.data_in = d;
        @(negedge clk);
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            drive(1'b0, '0);
            k++;
        end
        check(tag, out_q.size(), n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0);
        drive(1'b0, '0);
        reset = 1'b0;
        out_q.delete();
        ocyc_q.delete();
    endtask

    logic [IN_W-1:0] kept [$];
    logic [IN_W-1:0] acc1, acc2, acc3, rnd, exp_v;
    int e4, e8, nvalid;

    initial begin
        bus.in_dv   = 1'b0;
        bus.data_in = '0;

        // 1: reset wins over in_dv; nothing emerges afterwards while idle
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 14'd500);
            check("rst_out_dv", bus.out_dv, 1'b0);
            check("rst_data_out", bus.data_out, '0);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) drive(1'b0, '0);
        check("idle_no_strobe", out_q.size(), 0);
        check("idle_data_out", bus.data_out, '0);

        // 2: ramp 1..8, first output 3 edges after the 4th sample
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, IN_W'(i));
            if (i == 4) e4 = cyc;
            if (i == 8) e8 = cyc;
        end
        wait_out("ramp_count", 2, 20);
        if (out_q.size() >= 2) begin
            check("ramp_first", out_q[0], 14'd4);
            check("ramp_first_lat", ocyc_q[0], e4 + N);
            check("ramp_second", out_q[1], 14'h3FFC);
            check("ramp_second_lat", ocyc_q[1], e8 + N);
        end
        drive(1'b0, '0);
        check("hold_data_out", bus.data_out, 14'h3FFC);
        check("hold_out_dv", bus.out_dv, 1'b0);

        // 3: modular wrap, 8191 then -8192
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 14'd1);
        drive(1'b1, 14'd8191);
        for (int i = 0; i < 3; i++) drive(1'b1, 14'd2);
        drive(1'b1, 14'h2000);
        wait_out("wrap_count", 2, 20);
        if (out_q.size() >= 2) begin
            check("wrap_first", out_q[0], 14'd8191);
            check("wrap_second", out_q[1], 14'd3);
        end

        // 4: in_dv every other cycle, random data, closed-form comb reference
        do_reset();
        kept.delete();
        nvalid = 0;
        for (int i = 0; i < 32; i++) begin
            rnd = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            drive(1'b1, rnd);
            nvalid++;
            if (nvalid % R == 0) kept.push_back(rnd);
            drive(1'b0, IN_W'($urandom_range(0, (1 << IN_W) - 1)));
        end
        wait_out("gap_count", 8, 20);
        for (int k = 0; k < out_q.size() && k < kept.size(); k++) begin
            int x0, x1, x2, x3;
            x0 = int'(kept[k]);
            x1 = (k >= 1) ? int'(kept[k-1]) : 0;
            x2 = (k >= 2) ? int'(kept[k-2]) : 0;
            x3 = (k >= 3) ? int'(kept[k-3]) : 0;
            exp_v = IN_W'(x0 - 3 * x1 + 3 * x2 - x3);
            check($sformatf("gap_val%0d", k), out_q[k], exp_v);
            if (k >= 1) check($sformatf("gap_period%0d", k), ocyc_q[k] - ocyc_q[k-1], 8);
        end

        // 5: reset while a kept sample is in flight
        do_reset();
        for (int i = 1; i <= 12; i++) drive(1'b1, IN_W'(i * 37));
        reset = 1'b1;
        drive(1'b0, '0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b0, '0);
        check("flight_dropped", out_q.size(), 2);
        out_q.delete();
        ocyc_q.delete();
        drive(1'b1, 14'd7);
        drive(1'b1, 14'd9);
        drive(1'b1, 14'd11);
        drive(1'b1, 14'd1234);
        wait_out("post_rst_count", 1, 20);
        if (out_q.size() >= 1) check("post_rst_val", out_q[0], 14'd1234);

        // 6: behavioural integrator chain feeding the combs, constant input 10
        do_reset();
        acc1 = '0;
        acc2 = '0;
        acc3 = '0;
        for (int i = 0; i < 48; i++) begin
            acc1 = acc1 + 14'd10;
            acc2 = acc2 + acc1;
            acc3 = acc3 + acc2;
            drive(1'b1, acc3);
        end
        wait_out("chain_count", 12, 20);
        for (int k = 3; k < out_q.size(); k++)
            check($sformatf("chain_val%0d", k), out_q[k], 14'd640);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
